ar_arbiter: RTL and testbench
=============================

AR_ARBITER -- requirements
Module: ar_arbiter

Interface
REQ-001 SHALL take parameter N_CPU, default param_pkg N_CPU, the number of ACE masters.
REQ-002 SHALL take parameter FIFO_DEPTH, default 4 (power of two, >=2), the request-queue depth.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port resetn, input, 1, the reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port ar_valid, input, [N_CPU], the per-master AR valid.
REQ-006 SHALL have port ar_ready, output, [N_CPU], the per-master AR ready.
REQ-007 SHALL have port ar_addr, input, [N_CPU][ADDR_WIDTH], the byte address.
REQ-008 SHALL have port ar_id, input, [N_CPU][ID_WIDTH], the master transaction ID.
REQ-009 SHALL have port ar_len, input, [N_CPU][AR_LEN_WIDTH], the burst length minus 1.
REQ-010 SHALL have port ar_snoop, input, [N_CPU][4], the ACE ARSNOOP.
REQ-011 SHALL have port rack, input, [N_CPU], the per-master RACK.
REQ-012 SHALL have port ar_pop_i, input, 1, the consumer pop.
REQ-013 SHALL have port ar_empty_o, output, 1, the queue-empty flag.
REQ-014 SHALL have port ar_request_o, output, [AR_Q_DATA_WIDTH], the head-of-queue packed request.
REQ-015 SHALL have port snoop_err_o, output, 1, the unsupported-snoop pulse.

Function
REQ-016 SHALL pack each request as: ID field = {ar_id, cpu index[CPU_ID_WIDTH-1:0]}, so the CPU index occupies the low bits; LINE_ADDR = ar_addr[ADDR_WIDTH-1 : DCACHE_BLOCK_WIDTH+DCACHE_BYTE_OFFSET]; LEN = ar_len; SNOOP = ar_snoop. Each field is placed at its AR_*_MSB/LSB positions.
REQ-017 SHALL treat master i as eligible when ar_valid[i] is high, outstanding_r[i] is low, and the queue is not full.
REQ-018 SHALL grant the first eligible index at or above rr_ptr_r, wrapping modulo N_CPU.
REQ-019 SHALL drive ar_ready one-hot on the granted index, or all zero if none is eligible. ar_ready is combinational and may depend on ar_valid.
REQ-020 SHALL, on each handshake (ar_valid[i] & ar_ready[i]):
- push the packed word into the queue in the same edge;
- set outstanding_r[i];
- set rr_ptr_r to (i+1) mod N_CPU.
REQ-021 SHALL leave rr_ptr_r unchanged in cycles with no handshake.
REQ-022 SHALL clear outstanding_r[i] on rack[i]; rack[i] while outstanding_r[i] is low is ignored.
REQ-023 SHALL have a request latency of one cycle: ar_empty_o falls and ar_request_o is valid the cycle after a handshake into an empty queue.
REQ-024 SHALL present ar_request_o as the registered head entry, stable until popped.
REQ-025 SHALL ignore ar_pop_i while ar_empty_o is high.
REQ-026 SHALL compute full from registered state only. When the queue is full, no ar_ready is asserted, even if ar_pop_i is high in that cycle.
REQ-027 SHALL, on simultaneous push and pop with the queue neither full nor empty, keep the occupancy unchanged.
REQ-028 SHALL wrap the read and write pointers modulo FIFO_DEPTH, using an extra MSB to distinguish full from empty.
REQ-029 SHALL forward ar_snoop values other than 4'b0010 (ReadClean) and 4'b0111 (ReadUnique) unchanged, and pulse snoop_err_o high for exactly one cycle, registered, the cycle after that handshake.

Reset
REQ-030 SHALL, on resetn low (asynchronous):
- clear outstanding_r, rr_ptr_r and both queue pointers;
- discard all queue contents;
- drive ar_empty_o=1, ar_request_o=0, snoop_err_o=0, ar_ready=0.
REQ-031 SHALL, when reset is asserted mid-transfer, drop all pending and in-flight requests without any completion signalling.

Structure
REQ-032 SHALL import N_CPU, ADDR_WIDTH, ID_WIDTH, CPU_ID_WIDTH, AR_LEN_WIDTH, AR_ID_WIDTH (=ID_WIDTH+CPU_ID_WIDTH), AR_Q_DATA_WIDTH, the AR_*_MSB/LSB field positions, DCACHE_BLOCK_WIDTH, DCACHE_BYTE_OFFSET and the snoop encodings (SNOOP_RC=4'b0010, SNOOP_RU=4'b0111) from param_pkg.
REQ-033 SHALL instantiate the queue as one sub-module, sync_fifo (parameters WIDTH and DEPTH; ports push, pop, data in, data out, empty, full). The arbiter logic stays in ar_arbiter.

Verification
REQ-034 SHALL cover: N_CPU=4, all ar_valid high from reset with rack returned after each pop -> grant order 0,1,2,3,0.
REQ-035 SHALL cover: master 1 sends ReadUnique to 0x1040 with id=3, len=1 -> one cycle later ar_empty_o=0, ID field={3,1}, LINE_ADDR=0x1040>>offset, SNOOP=0111, LEN=1.
REQ-036 SHALL cover: master 2 handshakes and rack[2] is withheld -> ar_ready[2] stays 0 while ar_valid[2] is high; rack[2] pulse -> master 2 re-granted the next cycle.
REQ-037 SHALL cover: FIFO_DEPTH=4, four pushes, no pops -> all ar_ready=0; one pop -> one further grant in the following cycle.
REQ-038 SHALL cover: ar_snoop=4'b1011 accepted -> request queued unchanged and snoop_err_o high for exactly one cycle.
REQ-039 SHALL cover: resetn low with 3 entries queued and 2 masters outstanding -> immediately ar_empty_o=1 and ar_ready=0; after release, fresh grants resume from index 0.

Source files
------------

// File: rtl/param_pkg.sv
// Shared AR-channel parameters: widths, packed request layout and snoop encodings.
package param_pkg;

  localparam int unsigned N_CPU              = 4;
  localparam int unsigned ADDR_WIDTH         = 32;
  localparam int unsigned ID_WIDTH           = 4;
  localparam int unsigned CPU_ID_WIDTH       = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int unsigned AR_LEN_WIDTH       = 8;
  localparam int unsigned AR_ID_WIDTH        = ID_WIDTH + CPU_ID_WIDTH;

  // 64-byte cache lines: 4-byte words, 16 words per line
  localparam int unsigned DCACHE_BYTE_OFFSET = 2;
  localparam int unsigned DCACHE_BLOCK_WIDTH = 4;
  localparam int unsigned LINE_LSB           = DCACHE_BLOCK_WIDTH + DCACHE_BYTE_OFFSET;
  localparam int unsigned LINE_ADDR_WIDTH    = ADDR_WIDTH - LINE_LSB;

  // Packed request layout, LSB first: snoop, len, line address, {id, cpu}
  localparam int unsigned AR_SNOOP_LSB       = 0;
  localparam int unsigned AR_SNOOP_MSB       = AR_SNOOP_LSB + 3;
  localparam int unsigned AR_LEN_LSB         = AR_SNOOP_MSB + 1;
  localparam int unsigned AR_LEN_MSB         = AR_LEN_LSB + AR_LEN_WIDTH - 1;
  localparam int unsigned AR_ADDR_LSB        = AR_LEN_MSB + 1;
  localparam int unsigned AR_ADDR_MSB        = AR_ADDR_LSB + LINE_ADDR_WIDTH - 1;
  localparam int unsigned AR_ID_LSB          = AR_ADDR_MSB + 1;
  localparam int unsigned AR_ID_MSB          = AR_ID_LSB + AR_ID_WIDTH - 1;
  localparam int unsigned AR_Q_DATA_WIDTH    = AR_ID_MSB + 1;

  localparam logic [3:0] SNOOP_RC = 4'b0010;  // ReadClean
  localparam logic [3:0] SNOOP_RU = 4'b0111;  // ReadUnique

  function automatic logic snoop_supported(input logic [3:0] snoop);
    return (snoop == SNOOP_RC) || (snoop == SNOOP_RU);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage; read data is the head entry, zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  // Extra MSB on each pointer separates full from empty when the index bits match
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_en;
  logic             pop_en;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign rdata   = empty ? '0 : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance; reset empties the queue by aligning both pointers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_en) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_en)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  // Storage write; stale contents are never visible because rdata is gated by empty
  always_ff @(posedge clk) begin
    if (push_en) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ar_arbiter.sv
// Round-robin AR arbiter for ACE masters feeding a single request queue.
// Each master may have one read outstanding until it returns RACK.
module ar_arbiter
  import param_pkg::*;
#(
  parameter int unsigned N_CPU      = param_pkg::N_CPU,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic [N_CPU-1:0]                         ar_valid,
  output logic [N_CPU-1:0]                         ar_ready,
  input  logic [N_CPU-1:0][ADDR_WIDTH-1:0]         ar_addr,
  input  logic [N_CPU-1:0][ID_WIDTH-1:0]           ar_id,
  input  logic [N_CPU-1:0][AR_LEN_WIDTH-1:0]       ar_len,
  input  logic [N_CPU-1:0][3:0]                    ar_snoop,
  input  logic [N_CPU-1:0]                         rack,
  input  logic                                     ar_pop_i,
  output logic                                     ar_empty_o,
  output logic [AR_Q_DATA_WIDTH-1:0]               ar_request_o,
  output logic                                     snoop_err_o
);

  localparam int unsigned PTR_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

  logic [N_CPU-1:0]           outstanding_r;
  logic [N_CPU-1:0]           outstanding_d;
  logic [PTR_W-1:0]           rr_ptr_r;
  logic [PTR_W-1:0]           rr_ptr_d;
  logic                       snoop_err_r;
  logic                       fifo_full;
  logic [N_CPU-1:0]           eligible;
  logic                       grant_vld;
  logic [PTR_W-1:0]           grant_idx;
  logic [AR_Q_DATA_WIDTH-1:0] req_word;

  // Reset term keeps ar_ready low while resetn is held, regardless of ar_valid
  assign eligible = ar_valid & ~outstanding_r & {N_CPU{~fifo_full & resetn}};

  // Rotating-priority search: first eligible index at or above rr_ptr_r
  always_comb begin
    int unsigned idx;
    logic [PTR_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = 0; k < N_CPU; k++) begin
      idx  = (32'(rr_ptr_r) + k) % N_CPU;
      cand = PTR_W'(idx);
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign ar_ready = grant_vld ? (N_CPU'(1) << grant_idx) : '0;

  // Pack the granted master's request into the queue word
  always_comb begin
    req_word = '0;
    req_word[AR_ID_MSB:AR_ID_LSB]       = {ar_id[grant_idx], CPU_ID_WIDTH'(grant_idx)};
    req_word[AR_ADDR_MSB:AR_ADDR_LSB]   = ar_addr[grant_idx][ADDR_WIDTH-1:LINE_LSB];
    req_word[AR_LEN_MSB:AR_LEN_LSB]     = ar_len[grant_idx];
    req_word[AR_SNOOP_MSB:AR_SNOOP_LSB] = ar_snoop[grant_idx];
  end

  // Next-state: RACK retires the outstanding read, a grant sets it and advances the pointer
  always_comb begin
    outstanding_d = outstanding_r & ~rack;
    rr_ptr_d      = rr_ptr_r;
    if (grant_vld) begin
      outstanding_d[grant_idx] = 1'b1;
      rr_ptr_d = (grant_idx == PTR_W'(N_CPU - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Arbiter state and the one-cycle unsupported-snoop flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding_r <= '0;
      rr_ptr_r      <= '0;
      snoop_err_r   <= 1'b0;
    end else begin
      outstanding_r <= outstanding_d;
      rr_ptr_r      <= rr_ptr_d;
      snoop_err_r   <= grant_vld && !snoop_supported(ar_snoop[grant_idx]);
    end
  end

  assign snoop_err_o = snoop_err_r;

  sync_fifo #(
    .WIDTH (AR_Q_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ar_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (grant_vld),
    .pop    (ar_pop_i),
    .wdata  (req_word),
    .rdata  (ar_request_o),
    .empty  (ar_empty_o),
    .full   (fifo_full)
  );

endmodule

// File: tb/tb_ar_arbiter.sv
// Scenario bench for ar_arbiter: expected queue words are pushed when a grant is
// expected and popped/compared when the DUT presents its head entry.
module tb_ar_arbiter;
  import param_pkg::*;

  localparam int unsigned NC    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned W     = AR_Q_DATA_WIDTH;

  logic                              clk = 1'b0;
  logic                              resetn;
  logic [NC-1:0]                     ar_valid;
  logic [NC-1:0]                     ar_ready;
  logic [NC-1:0][ADDR_WIDTH-1:0]     ar_addr;
  logic [NC-1:0][ID_WIDTH-1:0]       ar_id;
  logic [NC-1:0][AR_LEN_WIDTH-1:0]   ar_len;
  logic [NC-1:0][3:0]                ar_snoop;
  logic [NC-1:0]                     rack;
  logic                              ar_pop_i;
  logic                              ar_empty_o;
  logic [W-1:0]                      ar_request_o;
  logic                              snoop_err_o;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  ar_arbiter #(
    .N_CPU      (NC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ar_valid     (ar_valid),
    .ar_ready     (ar_ready),
    .ar_addr      (ar_addr),
    .ar_id        (ar_id),
    .ar_len       (ar_len),
    .ar_snoop     (ar_snoop),
    .rack         (rack),
    .ar_pop_i     (ar_pop_i),
    .ar_empty_o   (ar_empty_o),
    .ar_request_o (ar_request_o),
    .snoop_err_o  (snoop_err_o)
  );

  // Expected 44-bit word: {id[3:0], cpu[1:0], addr[31:6], len[7:0], snoop[3:0]}
  function automatic logic [43:0] pack(input int cpu, input logic [3:0] id,
                                       input logic [31:0] addr, input logic [7:0] len,
                                       input logic [3:0] snp);
    return {id, 2'(cpu), addr[31:6], len, snp};
  endfunction

  function automatic logic [31:0] m_addr(input int m);
    return 32'h1000 + 32'(m) * 32'h100 + 32'h5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic [31:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [3:0] snp);
    ar_addr[m]  = addr;
    ar_id[m]    = id;
    ar_len[m]   = len;
    ar_snoop[m] = snp;
  endtask

  task automatic set_all_masters();
    for (int m = 0; m < NC; m++) set_master(m, m_addr(m), 4'(m + 8), 8'(m + 2), SNOOP_RC);
  endtask

  task automatic do_reset();
    resetn   = 1'b0;
    ar_valid = '0;
    rack     = '0;
    ar_pop_i = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    ar_valid = '1;
    rack     = '0;
    ar_pop_i = 1'b1;
    set_all_masters();
    tick();
    #2;
    checks++;
    if (ar_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", ar_ready);
    end
    checks++;
    if (ar_empty_o !== 1'b1) begin
      errors++; $display("FAIL reset_empty: got %b expected 1", ar_empty_o);
    end
    checks++;
    if (ar_request_o !== '0) begin
      errors++; $display("FAIL reset_request: got %h expected 0", ar_request_o);
    end
    checks++;
    if (snoop_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_snoop_err: got %b expected 0", snoop_err_o);
    end
  endtask

  // All masters valid, each entry popped and RACKed the next cycle: grants 0,1,2,3,0
  task automatic test_round_robin();
    logic [3:0]   exp_rdy;
    logic [W-1:0] exp_w;
    do_reset();
    set_all_masters();
    for (int c = 0; c < 6; c++) begin
      ar_valid = (c < 5) ? '1 : '0;
      ar_pop_i = (c > 0);
      rack     = (c > 0) ? 4'(1 << ((c - 1) % 4)) : '0;
      exp_rdy  = (c < 5) ? 4'(1 << (c % 4)) : '0;
      #2;
      checks++;
      if (ar_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, ar_ready, exp_rdy);
      end
      if (c == 0) begin
        checks++;
        if (ar_empty_o !== 1'b1) begin
          errors++; $display("FAIL rr_empty_start: got %b expected 1", ar_empty_o);
        end
      end else begin
        exp_w = '0;
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        checks++;
        if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
          errors++;
          $display("FAIL rr_head[%0d]: got empty=%b req=%h expected empty=0 req=%h",
                   c, ar_empty_o, ar_request_o, exp_w);
        end
      end
      if (exp_rdy != 0)
        exp_q.push_back(pack(c % 4, 4'((c % 4) + 8), m_addr(c % 4), 8'((c % 4) + 2), SNOOP_RC));
      tick();
    end
    ar_pop_i = 1'b0;
    rack     = '0;
    #2;
    checks++;
    if (ar_empty_o !== 1'b1) begin
      errors++; $display("FAIL rr_empty_end: got %b expected 1", ar_empty_o);
    end
  endtask

  // Master 1 ReadUnique at 0x1040, id 3, len 1
  task automatic test_fields();
    logic [W-1:0] exp_w;
    do_reset();
    set_master(1, 32'h1040, 4'd3, 8'd1, SNOOP_RU);
    ar_valid = 4'b0010;
    #2;
    checks++;
    if (ar_ready !== 4'b0010) begin
      errors++; $display("FAIL fields_ready: got %b expected 0010", ar_ready);
    end
    exp_q.push_back(pack(1, 4'd3, 32'h1040, 8'd1, SNOOP_RU));
    tick();
    ar_valid = '0;
    #2;
    exp_w = '0;
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    checks++;
    if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
      errors++;
      $display("FAIL fields_head: got empty=%b req=%h expected empty=0 req=%h",
               ar_empty_o, ar_request_o, exp_w);
    end
    checks++;
    if (ar_request_o[43:38] !== 6'b0011_01) begin
      errors++; $display("FAIL fields_id: got %b expected 001101", ar_request_o[43:38]);
    end
    checks++;
    if (ar_request_o[37:12] !== 26'h41) begin
      errors++; $display("FAIL fields_line: got %h expected 41", ar_request_o[37:12]);
    end
    checks++;
    if (ar_request_o[11:4] !== 8'd1 || ar_request_o[3:0] !== 4'b0111) begin
      errors++;
      $display("FAIL fields_len_snoop: got len=%h snoop=%b expected len=01 snoop=0111",
               ar_request_o[11:4], ar_request_o[3:0]);
    end
    checks++;
    if (snoop_err_o !== 1'b0) begin
      errors++; $display("FAIL fields_snoop_err: got %b expected 0", snoop_err_o);
    end
    ar_pop_i = 1'b1;
    rack     = 4'b0010;
    tick();
    ar_pop_i = 1'b0;
    rack     = '0;
    #2;
    checks++;
    if (ar_empty_o !== 1'b1) begin
      errors++; $display("FAIL fields_empty_after_pop: got %b expected 1", ar_empty_o);
    end
  endtask

  // Master 2 blocked while its read is outstanding, re-granted the cycle after RACK
  task automatic test_outstanding();
    logic [W-1:0] exp_w;
    do_reset();
    set_master(2, 32'h2080, 4'd5, 8'd3, SNOOP_RC);
    ar_valid = 4'b0100;
    #2;
    checks++;
    if (ar_ready !== 4'b0100) begin
      errors++; $display("FAIL outst_first_ready: got %b expected 0100", ar_ready);
    end
    exp_q.push_back(pack(2, 4'd5, 32'h2080, 8'd3, SNOOP_RC));
    tick();
    for (int k = 0; k < 3; k++) begin
      ar_pop_i = (k == 0);
      #2;
      checks++;
      if (ar_ready !== 4'b0000) begin
        errors++; $display("FAIL outst_blocked[%0d]: got %b expected 0000", k, ar_ready);
      end
      if (k == 0) begin
        exp_w = '0;
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        checks++;
        if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
          errors++;
          $display("FAIL outst_head: got empty=%b req=%h expected empty=0 req=%h",
                   ar_empty_o, ar_request_o, exp_w);
        end
      end
      tick();
    end
    ar_pop_i = 1'b0;
    rack     = 4'b0100;
    #2;
    checks++;
    if (ar_ready !== 4'b0000) begin
      errors++; $display("FAIL outst_rack_cycle: got %b expected 0000", ar_ready);
    end
    tick();
    rack = '0;
    #2;
    checks++;
    if (ar_ready !== 4'b0100) begin
      errors++; $display("FAIL outst_regrant: got %b expected 0100", ar_ready);
    end
    tick();
    ar_valid = '0;
    rack     = 4'b0100;
    ar_pop_i = 1'b1;
    tick();
    rack     = '0;
    ar_pop_i = 1'b0;
  endtask

  // Four pushes fill the queue; pop while full still grants nothing, next cycle one grant
  task automatic test_full();
    logic [3:0]   exp_rdy;
    logic [W-1:0] exp_w;
    do_reset();
    set_all_masters();
    ar_valid = '1;
    for (int c = 0; c < 4; c++) begin
      rack    = (c > 0) ? 4'(1 << (c - 1)) : '0;
      exp_rdy = 4'(1 << c);
      #2;
      checks++;
      if (ar_ready !== exp_rdy) begin
        errors++; $display("FAIL full_fill[%0d]: got %b expected %b", c, ar_ready, exp_rdy);
      end
      exp_q.push_back(pack(c, 4'(c + 8), m_addr(c), 8'(c + 2), SNOOP_RC));
      tick();
    end
    rack     = 4'b1000;
    ar_pop_i = 1'b1;
    #2;
    checks++;
    if (ar_ready !== 4'b0000) begin
      errors++; $display("FAIL full_pop_no_grant: got %b expected 0000", ar_ready);
    end
    exp_w = '0;
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    checks++;
    if (ar_request_o !== exp_w) begin
      errors++; $display("FAIL full_head0: got %h expected %h", ar_request_o, exp_w);
    end
    tick();
    rack     = '0;
    ar_pop_i = 1'b0;
    #2;
    checks++;
    if (ar_ready !== 4'b0001) begin
      errors++; $display("FAIL full_one_grant: got %b expected 0001", ar_ready);
    end
    exp_q.push_back(pack(0, 4'd8, m_addr(0), 8'd2, SNOOP_RC));
    tick();
    #2;
    checks++;
    if (ar_ready !== 4'b0000) begin
      errors++; $display("FAIL full_again: got %b expected 0000", ar_ready);
    end
    ar_valid = '0;
    for (int d = 0; d < 4; d++) begin
      ar_pop_i = 1'b1;
      rack     = (d == 0) ? 4'b0001 : '0;
      #1;
      exp_w = '0;
      if (exp_q.size() > 0) exp_w = exp_q.pop_front();
      checks++;
      if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
        errors++;
        $display("FAIL full_drain[%0d]: got empty=%b req=%h expected empty=0 req=%h",
                 d, ar_empty_o, ar_request_o, exp_w);
      end
      tick();
    end
    ar_pop_i = 1'b0;
    rack     = '0;
    #2;
    checks++;
    if (ar_empty_o !== 1'b1) begin
      errors++; $display("FAIL full_drained_empty: got %b expected 1", ar_empty_o);
    end
  endtask

  // Unsupported snoop passes through unchanged with a single-cycle error pulse
  task automatic test_snoop_err();
    logic [W-1:0] exp_w;
    do_reset();
    set_master(3, 32'h3FC0, 4'hA, 8'h0F, 4'b1011);
    ar_valid = 4'b1000;
    #2;
    checks++;
    if (ar_ready !== 4'b1000 || snoop_err_o !== 1'b0) begin
      errors++;
      $display("FAIL snoop_grant: got ready=%b err=%b expected ready=1000 err=0",
               ar_ready, snoop_err_o);
    end
    exp_q.push_back(pack(3, 4'hA, 32'h3FC0, 8'h0F, 4'b1011));
    tick();
    ar_valid = '0;
    #2;
    checks++;
    if (snoop_err_o !== 1'b1) begin
      errors++; $display("FAIL snoop_err_pulse: got %b expected 1", snoop_err_o);
    end
    exp_w = '0;
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    checks++;
    if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
      errors++;
      $display("FAIL snoop_head: got empty=%b req=%h expected empty=0 req=%h",
               ar_empty_o, ar_request_o, exp_w);
    end
    ar_pop_i = 1'b1;
    rack     = 4'b1000;
    tick();
    ar_pop_i = 1'b0;
    rack     = '0;
    #2;
    checks++;
    if (snoop_err_o !== 1'b0) begin
      errors++; $display("FAIL snoop_err_end: got %b expected 0", snoop_err_o);
    end
  endtask

  // Reset with 3 queued entries and masters 1,2 outstanding; grants restart at index 0
  task automatic test_reset_mid();
    logic [W-1:0] exp_w;
    do_reset();
    set_all_masters();
    ar_valid = 4'b0111;
    #2;
    checks++;
    if (ar_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_g0: got %b expected 0001", ar_ready);
    end
    tick();
    ar_valid = 4'b0110;
    rack     = 4'b0001;
    #2;
    checks++;
    if (ar_ready !== 4'b0010) begin
      errors++; $display("FAIL rmid_g1: got %b expected 0010", ar_ready);
    end
    tick();
    rack = '0;
    #2;
    checks++;
    if (ar_ready !== 4'b0100) begin
      errors++; $display("FAIL rmid_g2: got %b expected 0100", ar_ready);
    end
    tick();
    ar_valid = '1;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ar_empty_o !== 1'b1 || ar_ready !== 4'b0000 || ar_request_o !== '0) begin
      errors++;
      $display("FAIL rmid_async: got empty=%b ready=%b req=%h expected empty=1 ready=0000 req=0",
               ar_empty_o, ar_ready, ar_request_o);
    end
    exp_q.delete();
    tick();
    resetn = 1'b1;
    #2;
    checks++;
    if (ar_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_resume0: got %b expected 0001", ar_ready);
    end
    exp_q.push_back(pack(0, 4'd8, m_addr(0), 8'd2, SNOOP_RC));
    tick();
    #2;
    checks++;
    if (ar_ready !== 4'b0010) begin
      errors++; $display("FAIL rmid_resume1: got %b expected 0010", ar_ready);
    end
    exp_w = '0;
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    checks++;
    if (ar_empty_o !== 1'b0 || ar_request_o !== exp_w) begin
      errors++;
      $display("FAIL rmid_head: got empty=%b req=%h expected empty=0 req=%h",
               ar_empty_o, ar_request_o, exp_w);
    end
    ar_valid = '0;
  endtask

  initial begin
    resetn   = 1'b0;
    ar_valid = '0;
    ar_addr  = '0;
    ar_id    = '0;
    ar_len   = '0;
    ar_snoop = '0;
    rack     = '0;
    ar_pop_i = 1'b0;
    test_reset();
    test_round_robin();
    test_fields();
    test_outstanding();
    test_full();
    test_snoop_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
